hilo_muldiv_unit: RTL and testbench
===================================

Name: hilo_muldiv_unit

Overview:
Execute-stage companion to the decoder. Consumes the MULTU/DIVU strobes (the decoder's lowrite/hiwrite path) plus the rs/rt operand values, and computes the 64-bit product or the quotient/remainder iteratively, one bit per cycle. Holds the architectural HI/LO registers read by MFHI/MFLO. Raises a stall to the pipeline while a result is pending and a dependent instruction arrives.

Parameters:
WIDTH, 32, operand and HI/LO register width
CNT_W, 6, iteration counter width (must hold WIDTH)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
start_mult  in  1  MULTU issued this cycle (decoded, pipeline not stalled)
start_div  in  1  DIVU issued this cycle
signed_op  in  1  signed MULT/DIV request (ignored unless SIGNED_MULDIV_EN)
op_a  in  WIDTH  rs value (multiplicand / dividend)
op_b  in  WIDTH  rt value (multiplier / divisor)
cancel  in  1  flush from exception/eret; aborts the operation in flight
hilo_read  in  1  MFHI or MFLO (decoder hi_used | lo_used) in this stage
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register
busy  out  1  operation in flight
done  out  1  one-cycle pulse: HI/LO just updated
stall  out  1  hold the upstream pipeline

Behaviour:
- Reset (async, rst=1): hi=0, lo=0, busy=0, done=0, state=IDLE, counter=0. Reset asserted mid-operation discards the operation. HI/LO stay 0.
- States:
  - IDLE: if cancel=0 and (start_mult|start_div), latch operands and op type, counter=0, go to RUN.
  - RUN: one iteration per cycle; counter increments; after WIDTH iterations go to IDLE, write hi/lo, pulse done.
- Start priority: start_mult and start_div together is illegal; mult wins.
- Start while busy: ignored. stall is asserted, so upstream re-presents the instruction.
- cancel: in RUN, return to IDLE next edge, HI/LO unchanged, no done. In IDLE, cancel suppresses a same-cycle start.
- Latency: start sampled at edge k → busy=1 from k to k+WIDTH → hi/lo valid and done=1 after edge k+WIDTH → busy=0 in that same cycle.
- busy = (state==RUN). done is registered and lasts exactly one cycle.
- stall = busy & (hilo_read | start_mult | start_div). This is combinational.
- Multiply (unsigned): shift-add over a 2*WIDTH accumulator; hi = upper WIDTH bits, lo = lower WIDTH bits of op_a*op_b.
- Divide (unsigned): restoring divide; lo = quotient, hi = remainder.
- Divide by zero: runs the full WIDTH cycles; result is lo = all ones, hi = op_a (dividend). Deterministic, no trap.
- hi/lo change only on done or reset. No bypass of an in-flight result; the consumer waits on stall.

Optional Feature:
SIGNED_MULDIV_EN
- Defined:
  - signed_op=1 converts operands to magnitudes at start and records the result signs.
  - Product sign = sign(a)^sign(b).
  - Quotient sign = sign(a)^sign(b); remainder sign = sign(a).
  - Negation is applied in the final cycle; latency is unchanged.
  - Divide by zero: lo = all ones, hi = op_a unmodified.
- Undefined: signed_op is ignored and all operations are unsigned; no extra logic.

Test Plan:
- Reset mid-RUN: start MULTU 7*6, assert rst at cycle 5 → hi=0, lo=0, busy=0 immediately; no done.
- MULTU op_a=0xFFFFFFFF, op_b=0xFFFFFFFF → after 32 cycles hi=0xFFFFFFFE, lo=0x00000001, done for 1 cycle, busy low at cycle 32.
- DIVU op_a=100, op_b=7 → lo=14, hi=2. MFLO (hilo_read=1) asserted at cycle 3 → stall=1 until done, 0 after.
- DIVU op_a=0x12345678, op_b=0 → lo=0xFFFFFFFF, hi=0x12345678 after 32 cycles.
- Cancel/back-to-back:
  - Start MULTU 3*5, cancel at cycle 10 → HI/LO keep prior values, no done.
  - Then start DIVU while busy → stall=1 and start ignored; re-issued after IDLE → completes normally.
- SIGNED_MULDIV_EN: signed_op=1, MULT -3*5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1. DIV -7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. With the macro undefined, the same DIV gives unsigned results.

Source files
------------

// File: rtl/hilo_muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: one bit per cycle, WIDTH cycles per MULTU/DIVU.
// Optional signed MULT/DIV support is enabled by defining SIGNED_MULDIV_EN.
module hilo_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cancel,
    input  logic             hilo_read,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
        return ~x + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
        return ~x + {{(2*WIDTH-1){1'b0}}, 1'b1};
    endfunction

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 is_div_q, is_div_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]     a_raw_q, a_raw_d;
    logic                 b_zero_q, b_zero_d;
    logic                 neg_lo_q, neg_lo_d;
    logic                 neg_hi_q, neg_hi_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;

    logic                 sa_s, sb_s;
    logic [WIDTH-1:0]     a_mag_s, b_mag_s;
    logic [WIDTH:0]       mul_sum_s;
    logic                 div_ge_s;
    logic [WIDTH-1:0]     div_rem_s;
    logic [2*WIDTH-1:0]   step_s;
    logic [2*WIDTH-1:0]   prod_s;

`ifndef SIGNED_MULDIV_EN
    logic unused_signed_op_s;
    assign unused_signed_op_s = signed_op;
`endif

    // Operand conditioning: magnitudes and result signs captured at start.
    always_comb begin
`ifdef SIGNED_MULDIV_EN
        sa_s    = signed_op & op_a[WIDTH-1];
        sb_s    = signed_op & op_b[WIDTH-1];
        a_mag_s = sa_s ? neg_w(op_a) : op_a;
        b_mag_s = sb_s ? neg_w(op_b) : op_b;
`else
        sa_s    = 1'b0;
        sb_s    = 1'b0;
        a_mag_s = op_a;
        b_mag_s = op_b;
`endif
    end

    // One shift-add or restoring-divide iteration on the shared accumulator.
    always_comb begin
        mul_sum_s = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                  + (acc_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
        div_ge_s  = ({acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} >= {1'b0, mcand_q});
        // The true difference is below the divisor, so WIDTH-bit wraparound is exact.
        div_rem_s = div_ge_s ? ({acc_q[2*WIDTH-2:WIDTH], acc_q[WIDTH-1]} - mcand_q)
                             : {acc_q[2*WIDTH-2:WIDTH], acc_q[WIDTH-1]};
        if (is_div_q) begin
            step_s = {div_rem_s, acc_q[WIDTH-2:0], div_ge_s};
        end else begin
            step_s = {mul_sum_s, acc_q[WIDTH-1:1]};
        end
    end

    // Sequencer next state and HI/LO write-back.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        a_raw_d  = a_raw_q;
        b_zero_d = b_zero_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        prod_s   = {(2*WIDTH){1'b0}};
        case (state_q)
            S_IDLE: begin
                if (!cancel && (start_mult || start_div)) begin
                    state_d  = S_RUN;
                    cnt_d    = {CNT_W{1'b0}};
                    is_div_d = ~start_mult;
                    mcand_d  = start_mult ? a_mag_s : b_mag_s;
                    acc_d    = {{WIDTH{1'b0}}, (start_mult ? b_mag_s : a_mag_s)};
                    a_raw_d  = op_a;
                    b_zero_d = (op_b == {WIDTH{1'b0}});
                    neg_lo_d = sa_s ^ sb_s;
                    neg_hi_d = sa_s;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (cancel) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = step_s;
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (cnt_q == LAST_CNT) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                        if (!is_div_q) begin
                            prod_s = neg_lo_q ? neg_2w(step_s) : step_s;
                            hi_d   = prod_s[2*WIDTH-1:WIDTH];
                            lo_d   = prod_s[WIDTH-1:0];
                        end else if (b_zero_q) begin
                            hi_d = a_raw_q;
                            lo_d = {WIDTH{1'b1}};
                        end else begin
                            lo_d = neg_lo_q ? neg_w(step_s[WIDTH-1:0]) : step_s[WIDTH-1:0];
                            hi_d = neg_hi_q ? neg_w(step_s[2*WIDTH-1:WIDTH])
                                            : step_s[2*WIDTH-1:WIDTH];
                        end
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= {CNT_W{1'b0}};
            is_div_q <= 1'b0;
            acc_q    <= {(2*WIDTH){1'b0}};
            mcand_q  <= {WIDTH{1'b0}};
            a_raw_q  <= {WIDTH{1'b0}};
            b_zero_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            hi_q     <= {WIDTH{1'b0}};
            lo_q     <= {WIDTH{1'b0}};
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            a_raw_q  <= a_raw_d;
            b_zero_q <= b_zero_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign hi    = hi_q;
    assign lo    = lo_q;
    assign done  = done_q;
    assign busy  = (state_q == S_RUN);
    assign stall = busy & (hilo_read | start_mult | start_div);

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit: directed table, random ops against
// an arithmetic reference model, and hand-written stall/cancel/reset sequences.
module tb_hilo_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst, start_mult, start_div, signed_op, cancel, hilo_read;
    logic [31:0] op_a, op_b;
    logic [31:0] hi, lo;
    logic        busy, done, stall;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] exp_hi, exp_lo;

    typedef struct {
        logic        dv;
        logic        sg;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eh;
        logic [31:0] el;
    } vec_t;

    vec_t tbl[9];

    hilo_muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start_mult(start_mult), .start_div(start_div),
        .signed_op(signed_op), .op_a(op_a), .op_b(op_b), .cancel(cancel),
        .hilo_read(hilo_read), .hi(hi), .lo(lo), .busy(busy), .done(done),
        .stall(stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    task automatic model(input logic dv, input logic sg, input logic [31:0] a,
                         input logic [31:0] b, output logic [31:0] eh, output logic [31:0] el);
        logic [63:0] p;
        longint sa, sb, q, r;
        logic use_s;
        use_s = 1'b0;
`ifdef SIGNED_MULDIV_EN
        use_s = sg;
`endif
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!dv) begin
            if (use_s) p = sa * sb;
            else       p = {32'd0, a} * {32'd0, b};
            eh = p[63:32];
            el = p[31:0];
        end else if (b == 32'd0) begin
            el = 32'hFFFF_FFFF;
            eh = a;
        end else if (use_s) begin
            q  = sa / sb;
            r  = sa % sb;
            el = q[31:0];
            eh = r[31:0];
        end else begin
            el = a / b;
            eh = a % b;
        end
    endtask

    task automatic run_op(input logic dv, input logic sg, input logic [31:0] a,
                          input logic [31:0] b, input string nm);
        logic [31:0] eh, el;
        int lat;
        model(dv, sg, a, b, eh, el);
        start_mult = ~dv; start_div = dv; signed_op = sg; op_a = a; op_b = b;
        @(posedge clk); #1;
        start_mult = 1'b0; start_div = 1'b0; signed_op = 1'b0;
        chk({nm, "_busy"}, 64'(busy), 64'd1);
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (done) begin lat = n; break; end
        end
        chk({nm, "_latency"}, 64'(lat), 64'd32);
        chk({nm, "_hi"}, 64'(hi), 64'(eh));
        chk({nm, "_lo"}, 64'(lo), 64'(el));
        chk({nm, "_busy_end"}, 64'(busy), 64'd0);
        @(posedge clk); #1;
        chk({nm, "_done_pulse"}, 64'(done), 64'd0);
        exp_hi = eh;
        exp_lo = el;
    endtask

    initial begin
        logic        dv, sg;
        logic [31:0] a, b;
        int          lat, dcount;

        rst = 1'b1; start_mult = 1'b0; start_div = 1'b0; signed_op = 1'b0;
        cancel = 1'b0; hilo_read = 1'b0; op_a = 32'd0; op_b = 32'd0;
        exp_hi = 32'd0; exp_lo = 32'd0;

        tbl[0] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        tbl[1] = '{1'b1, 1'b0, 32'd100, 32'd7, 32'd2, 32'd14};
        tbl[2] = '{1'b1, 1'b0, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF};
        tbl[3] = '{1'b0, 1'b0, 32'd0, 32'h0001_2345, 32'd0, 32'd0};
        tbl[4] = '{1'b0, 1'b0, 32'h8000_0000, 32'd2, 32'd1, 32'd0};
        tbl[5] = '{1'b1, 1'b0, 32'd5, 32'd9, 32'd5, 32'd0};
        tbl[6] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF};
`ifdef SIGNED_MULDIV_EN
        tbl[7] = '{1'b0, 1'b1, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
        tbl[8] = '{1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
`else
        tbl[7] = '{1'b0, 1'b1, 32'hFFFF_FFFD, 32'd5, 32'd4, 32'hFFFF_FFF1};
        tbl[8] = '{1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'd1, 32'h7FFF_FFFC};
`endif

        repeat (2) @(posedge clk);
        #1;
        chk("reset_hi", 64'(hi), 64'd0);
        chk("reset_lo", 64'(lo), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) begin
            run_op(tbl[i].dv, tbl[i].sg, tbl[i].a, tbl[i].b, $sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d_hi_const", i), 64'(hi), 64'(tbl[i].eh));
            chk($sformatf("tbl%0d_lo_const", i), 64'(lo), 64'(tbl[i].el));
        end

        for (int i = 0; i < 24; i++) begin
            dv = 1'($urandom_range(0, 1));
            sg = 1'($urandom_range(0, 1));
            a  = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = $urandom;
                2:       b = 32'($urandom_range(1, 255));
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            run_op(dv, sg, a, b, $sformatf("rnd%0d", i));
        end

        // DIVU 100/7 with MFLO arriving at cycle 3: stall until done.
        start_div = 1'b1; op_a = 32'd100; op_b = 32'd7;
        @(posedge clk); #1;
        start_div = 1'b0;
        for (int n = 1; n <= 32; n++) begin
            @(posedge clk); #1;
            if (n == 3) hilo_read = 1'b1;
            if (n == 32) chk("stall_seq_done", 64'(done), 64'd1);
            if (n >= 3) begin
                @(negedge clk);
                chk($sformatf("stall_c%0d", n), 64'(stall), (n < 32) ? 64'd1 : 64'd0);
            end
        end
        hilo_read = 1'b0;
        chk("stall_seq_hi", 64'(hi), 64'd2);
        chk("stall_seq_lo", 64'(lo), 64'd14);
        exp_hi = 32'd2; exp_lo = 32'd14;
        @(posedge clk); #1;

        // MULTU 3*5 cancelled at cycle 10: HI/LO keep prior values, no done.
        start_mult = 1'b1; op_a = 32'd3; op_b = 32'd5;
        @(posedge clk); #1;
        start_mult = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0;
        chk("cancel_busy", 64'(busy), 64'd0);
        dcount = 0;
        for (int n = 0; n < 40; n++) begin
            if (done) dcount++;
            @(posedge clk); #1;
        end
        chk("cancel_no_done", 64'(dcount), 64'd0);
        chk("cancel_hi", 64'(hi), 64'(exp_hi));
        chk("cancel_lo", 64'(lo), 64'(exp_lo));

        // Cancel in IDLE suppresses a same-cycle start.
        cancel = 1'b1; start_mult = 1'b1; op_a = 32'd2; op_b = 32'd2;
        @(posedge clk); #1;
        cancel = 1'b0; start_mult = 1'b0;
        chk("idle_cancel_busy", 64'(busy), 64'd0);

        // DIVU presented while MULTU 9*9 runs: stalled and ignored, then re-issued.
        start_mult = 1'b1; op_a = 32'd9; op_b = 32'd9;
        @(posedge clk); #1;
        start_mult = 1'b0;
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (n == 3) start_div = 1'b0;
            if (done) begin lat = n; break; end
            if (n == 2) begin
                start_div = 1'b1; op_a = 32'd50; op_b = 32'd3;
                @(negedge clk);
                chk("busy_start_stall", 64'(stall), 64'd1);
            end
        end
        start_div = 1'b0;
        chk("busy_start_latency", 64'(lat), 64'd32);
        chk("busy_start_hi", 64'(hi), 64'd0);
        chk("busy_start_lo", 64'(lo), 64'd81);
        @(posedge clk); #1;
        run_op(1'b1, 1'b0, 32'd50, 32'd3, "reissue");
        chk("reissue_lo_const", 64'(lo), 64'd16);

        // Reset in the middle of MULTU 7*6.
        start_mult = 1'b1; op_a = 32'd7; op_b = 32'd6;
        @(posedge clk); #1;
        start_mult = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        chk("midrst_hi", 64'(hi), 64'd0);
        chk("midrst_lo", 64'(lo), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        dcount = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (done) dcount++;
        end
        chk("midrst_no_done", 64'(dcount), 64'd0);
        chk("midrst_busy_end", 64'(busy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
